line_raster: RTL
================

# line_raster

Parametrised all-octant Bresenham line rasterizer for the rasterizer stage. It accepts one pair of signed screen-space endpoints per command through a valid/ready handshake. It then streams every pixel of the line, from p to q inclusive, over a valid/ready pixel port at up to one pixel per cycle, and pulses `done` when the line is finished. Downstream it feeds the framebuffer/SRAM write arbiter; upstream it is driven by the triangle edge/primitive setup logic.

## Interface
- `COORD_W`, 16: signed width of every coordinate, in and out.
- `SCREEN_W`, 640: screen width in pixels. Used only when `LINE_RASTER_CLIP_EN` is defined.
- `SCREEN_H`, 480: screen height in pixels. Used only when `LINE_RASTER_CLIP_EN` is defined.

- `clk`  in  1  clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `start_valid`  in  1  command valid; `p_x`/`p_y`/`q_x`/`q_y` are stable while it is high.
- `start_ready`  out  1  high only in IDLE.
- `p_x`, `p_y`  in  COORD_W each  signed start point.
- `q_x`, `q_y`  in  COORD_W each  signed end point.
- `pix_valid`  out  1  `pix_x`/`pix_y` hold a pixel.
- `pix_ready`  in  1  downstream accepts the pixel.
- `pix_x`, `pix_y`  out  COORD_W each  signed pixel coordinate.
- `pix_last`  out  1  qualifies `pix_valid`; the pixel equals q.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  single-cycle pulse when the line is complete.

## Operation
- States: IDLE, SETUP, EMIT, DONE.
- **IDLE**
  - `start_ready`=1.
  - On `start_valid`&&`start_ready`, register p and q, then go to SETUP.
- **SETUP** (1 cycle)
  - dx=|q_x−p_x|, dy=−|q_y−p_y|, sx=(q_x≥p_x)?+1:−1, sy=(q_y≥p_y)?+1:−1.
  - err=dx+dy; x=p_x; y=p_y.
  - Go to EMIT.
- **EMIT**
  - `pix_valid`=1 with (x,y); `pix_last`=(x==q_x && y==q_y).
  - A handshake occurs when `pix_valid`&&`pix_ready`.
  - On handshake with `pix_last`: go to DONE.
  - On handshake without `pix_last`: e2=2·err.
    - If e2≥dy: err+=dy, x+=sx.
    - If e2≤dx: err+=dx, y+=sy.
    - Both updates use the pre-update err. Stay in EMIT.
  - Without a handshake, x, y and err hold. The output is stable while stalled.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- Arithmetic:
  - dx, dy, err and e2 are signed COORD_W+2 bits; no overflow is possible for any COORD_W inputs.
  - x and y are COORD_W bits. An endpoint is always reached, so there is no wrap.
- Pixel count = max(|Δx|,|Δy|)+1.
- Ordering: monotonic from p toward q. Every consecutive pair is 8-connected.
- Degenerate p==q: exactly one pixel, with `pix_last`=1.
- Horizontal, vertical and 45° lines, and all eight octants, need no special case.
- `start_valid` outside IDLE is ignored; the command is not consumed.

## Timing
- Reset values: state=IDLE, `start_ready`=1, `pix_valid`=0, `pix_last`=0, `pix_x`=`pix_y`=0, `busy`=0, `done`=0. Internal registers are cleared.
- Start handshake at cycle N → SETUP at N+1 → first `pix_valid` at N+2.
- Throughput is 1 pixel/cycle with `pix_ready` held high.
- Last pixel accepted at cycle M → `done`=1 at M+1 → `start_ready`=1 at M+2.
- Back-to-back lines therefore cost 3 overhead cycles.
- `pix_valid` never drops without a handshake (AXI-style): once asserted, it stays high until accepted.
- `n_rst` asserted mid-line aborts immediately and asynchronously to reset values. No `done` is issued and the line is lost.

## Configuration
- `LINE_RASTER_CLIP_EN` defined: pixels with x<0, x≥SCREEN_W, y<0 or y≥SCREEN_H are not presented.
  - In EMIT, an off-screen pixel drives `pix_valid`=0 and steps internally, 1 cycle per skipped pixel.
  - Reaching q when q is off-screen goes to DONE without `pix_last` ever asserting.
  - `done` is always issued.
- Undefined: no clipping; every pixel, including negative coordinates, is emitted. `SCREEN_W`/`SCREEN_H` are unused.

## Test plan
- p=(0,0), q=(5,2), `pix_ready`=1 → (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); `pix_last` on (5,2); first pixel 2 cycles after start; `done` 1 cycle after the last.
- p=(3,7), q=(1,0), steep negative octant → 8 pixels, y from 7 down to 0, x from 3 down to 1, ending exactly at (1,0).
- p=q=(9,9) → a single pixel (9,9) with `pix_last`=1, then `done`.
- p=(0,0), q=(4,4), `pix_ready` toggling 1,0,0,1,… → the held pixel stays stable while stalled; exactly 5 pixels on the diagonal, with no duplicates or drops.
- Reset pulsed during the 3rd pixel of (0,0)→(10,0) → all outputs go to reset values at once with no `done`; a new command afterwards rasterizes correctly.
- With `LINE_RASTER_CLIP_EN`, SCREEN_W=8: p=(−2,0), q=(9,0) → only x=0..7 emitted, `pix_last` never asserted, `done` pulses.

Source files
------------

// File: rtl/line_raster.sv
// All-octant Bresenham line rasterizer: one endpoint pair in, one pixel per cycle out.
// Optional clipping to SCREEN_W x SCREEN_H is enabled by defining LINE_RASTER_CLIP_EN.
module line_raster #(
    parameter int COORD_W  = 16,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic signed [COORD_W-1:0] p_x,
    input  logic signed [COORD_W-1:0] p_y,
    input  logic signed [COORD_W-1:0] q_x,
    input  logic signed [COORD_W-1:0] q_y,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic signed [COORD_W-1:0] pix_x,
    output logic signed [COORD_W-1:0] pix_y,
    output logic                      pix_last,
    output logic                      busy,
    output logic                      done
);

    localparam int EW = COORD_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EMIT, S_DONE} state_t;

    state_t                    r_state, w_state_nxt;
    logic signed [COORD_W-1:0] r_px, r_py, r_qx, r_qy;
    logic signed [COORD_W-1:0] r_x, r_y;
    logic signed [EW-1:0]      r_dx, r_dy, r_err;
    logic                      r_sx_neg, r_sy_neg;

    logic signed [EW-1:0]      w_diff_x, w_diff_y, w_abs_x, w_neg_abs_y;
    logic signed [EW-1:0]      w_e2, w_err_nxt;
    logic signed [COORD_W-1:0] w_x_step, w_y_step;
    logic                      w_step_x, w_step_y, w_last, w_on_screen, w_adv;

    // Deltas are formed two bits wider so |q-p| of any COORD_W endpoints fits.
    assign w_diff_x    = {{2{r_qx[COORD_W-1]}}, r_qx} - {{2{r_px[COORD_W-1]}}, r_px};
    assign w_diff_y    = {{2{r_qy[COORD_W-1]}}, r_qy} - {{2{r_py[COORD_W-1]}}, r_py};
    assign w_abs_x     = w_diff_x[EW-1] ? -w_diff_x : w_diff_x;
    assign w_neg_abs_y = w_diff_y[EW-1] ? w_diff_y : -w_diff_y;

    assign w_e2      = {r_err[EW-2:0], 1'b0};
    assign w_step_x  = (w_e2 >= r_dy);
    assign w_step_y  = (w_e2 <= r_dx);
    assign w_err_nxt = r_err + (w_step_x ? r_dy : {EW{1'b0}}) + (w_step_y ? r_dx : {EW{1'b0}});
    assign w_x_step  = r_sx_neg ? {COORD_W{1'b1}} : COORD_W'(1);
    assign w_y_step  = r_sy_neg ? {COORD_W{1'b1}} : COORD_W'(1);
    assign w_last    = (r_x == r_qx) && (r_y == r_qy);

`ifdef LINE_RASTER_CLIP_EN
    localparam logic signed [COORD_W-1:0] SCR_W = COORD_W'(SCREEN_W);
    localparam logic signed [COORD_W-1:0] SCR_H = COORD_W'(SCREEN_H);
    assign w_on_screen = !r_x[COORD_W-1] && (r_x < SCR_W) &&
                         !r_y[COORD_W-1] && (r_y < SCR_H);
`else
    assign w_on_screen = 1'b1;
`endif

    // Off-screen pixels advance without waiting for downstream.
    assign w_adv = (r_state == S_EMIT) && (!w_on_screen || pix_ready);

    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign pix_valid   = (r_state == S_EMIT) && w_on_screen;
    assign pix_last    = pix_valid && w_last;
    assign pix_x       = r_x;
    assign pix_y       = r_y;

    always_comb begin
        // NOTE: default assigned first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start_valid) w_state_nxt = S_SETUP;
            S_SETUP: w_state_nxt = S_EMIT;
            S_EMIT:  if (w_adv && w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_px     <= '0;
            r_py     <= '0;
            r_qx     <= '0;
            r_qy     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                S_IDLE: if (start_valid) begin
                    r_px <= p_x;
                    r_py <= p_y;
                    r_qx <= q_x;
                    r_qy <= q_y;
                end
                S_SETUP: begin
                    r_dx     <= w_abs_x;
                    r_dy     <= w_neg_abs_y;
                    r_err    <= w_abs_x + w_neg_abs_y;
                    r_sx_neg <= w_diff_x[EW-1];
                    r_sy_neg <= w_diff_y[EW-1];
                    r_x      <= r_px;
                    r_y      <= r_py;
                end
                S_EMIT: if (w_adv && !w_last) begin
                    r_err <= w_err_nxt;
                    if (w_step_x) r_x <= r_x + w_x_step;
                    if (w_step_y) r_y <= r_y + w_y_step;
                end
                default: ;
            endcase
        end
    end

endmodule
